// File: rtl/exc_cause_gen.sv
// Exception/interrupt cause generator: prioritises exception sources and the
// synchronised external interrupt, then produces registered Cause/EPC/Status
// write data, write enables and the PC-select for handler entry and ERET.
module exc_cause_gen #(
    parameter logic [31:0] VECTOR      = 32'h00000008,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        Intr,
    output logic        Inta,
    input  logic        Ov,
    input  logic        Sys,
    input  logic        Unimpl,
    input  logic        Eret,
    input  logic        Bd,
    input  logic        Stall,
    input  logic [31:0] Pc,
    input  logic [31:0] Sta,
    output logic [31:0] Cause,
    output logic [31:0] Epc_d,
    output logic [31:0] Sta_d,
    output logic        Wcau,
    output logic        Wepc,
    output logic        Wsta,
    output logic [1:0]  Selpc,
    output logic [31:0] Vec
);

    typedef enum logic [1:0] {
        StIdle,
        StEnter,
        StRet
    } state_e;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_EPC = 2'b01;
    localparam logic [1:0] SEL_VEC = 2'b10;

    // Status bit positions
    localparam int unsigned STA_IE  = 0;
    localparam int unsigned STA_EXL = 1;
    localparam int unsigned STA_IM0 = 8;

    state_e state_q, state_d;

    // Interrupt synchroniser, edge detector and pending flag
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   synced_prev_q;
    logic                   intr_rise;
    logic                   pending_q, pending_d;

    // Event decode
    logic       exc_any;
    logic       int_ok;
    logic [4:0] exc_code;

    // Registered outputs and their next-state values
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] sta_out_q, sta_out_d;
    logic        wcau_q, wcau_d;
    logic        wepc_q, wepc_d;
    logic        wsta_q, wsta_d;
    logic [1:0]  selpc_q, selpc_d;
    logic        inta_q, inta_d;

    // Shift the asynchronous interrupt level through the synchroniser chain
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            sync_q        <= '0;
            synced_prev_q <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], Intr};
            synced_prev_q <= synced;
        end
    end

    assign synced    = sync_q[SYNC_STAGES-1];
    assign intr_rise = synced & ~synced_prev_q;

    // Pending flag: a new edge wins over the acknowledge clearing it
    always_comb begin
        pending_d = pending_q;
        if (intr_rise) begin
            pending_d = 1'b1;
        end else if (inta_q) begin
            pending_d = 1'b0;
        end
    end

    // Pending flag register
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Priority encode the synchronous exception sources
    always_comb begin
        exc_any  = Unimpl | Sys | Ov;
        int_ok   = pending_q & Sta[STA_IE] & ~Sta[STA_EXL] & Sta[STA_IM0];
        exc_code = EXC_INT;
        if (Unimpl) begin
            exc_code = EXC_RI;
        end else if (Sys) begin
            exc_code = EXC_SYS;
        end else if (Ov) begin
            exc_code = EXC_OV;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d   = state_q;
        wcau_d    = 1'b0;
        wepc_d    = 1'b0;
        wsta_d    = 1'b0;
        selpc_d   = SEL_SEQ;
        inta_d    = 1'b0;
        // Cause[8] follows pending; everything else holds unless an entry is taken
        cause_d   = {cause_q[31:9], pending_q, cause_q[7:0]};
        epc_d     = epc_q;
        sta_out_d = sta_out_q;

        unique case (state_q)
            StIdle: begin
                if (!Stall) begin
                    if (exc_any || (!Eret && int_ok)) begin
                        state_d   = StEnter;
                        wcau_d    = 1'b1;
                        wepc_d    = 1'b1;
                        wsta_d    = 1'b1;
                        selpc_d   = SEL_VEC;
                        inta_d    = ~exc_any;
                        cause_d   = {Bd, 22'b0, pending_q, 1'b0, exc_code, 2'b00};
                        // Delay-slot instructions restart at the branch
                        epc_d     = Bd ? (Pc - 32'd4) : Pc;
                        sta_out_d = Sta | (32'd1 << STA_EXL);
                    end else if (Eret) begin
                        state_d   = StRet;
                        wsta_d    = 1'b1;
                        selpc_d   = SEL_EPC;
                        sta_out_d = Sta & ~(32'd1 << STA_EXL);
                    end
                end
            end
            StEnter: begin
                state_d = StIdle;
            end
            StRet: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset drops every write enable at once
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q   <= StIdle;
            cause_q   <= '0;
            epc_q     <= '0;
            sta_out_q <= '0;
            wcau_q    <= 1'b0;
            wepc_q    <= 1'b0;
            wsta_q    <= 1'b0;
            selpc_q   <= SEL_SEQ;
            inta_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            sta_out_q <= sta_out_d;
            wcau_q    <= wcau_d;
            wepc_q    <= wepc_d;
            wsta_q    <= wsta_d;
            selpc_q   <= selpc_d;
            inta_q    <= inta_d;
        end
    end

    assign Cause = cause_q;
    assign Epc_d = epc_q;
    assign Sta_d = sta_out_q;
    assign Wcau  = wcau_q;
    assign Wepc  = wepc_q;
    assign Wsta  = wsta_q;
    assign Selpc = selpc_q;
    assign Inta  = inta_q;
    assign Vec   = VECTOR;

endmodule

// File: tb/tb_exc_cause_gen.sv
// Directed bench for exc_cause_gen: expected output records are queued as
// stimulus is driven and compared one cycle later.
module tb_exc_cause_gen;

    logic        Clk;
    logic        Clr;
    logic        Intr;
    logic        Inta;
    logic        Ov;
    logic        Sys;
    logic        Unimpl;
    logic        Eret;
    logic        Bd;
    logic        Stall;
    logic [31:0] Pc;
    logic [31:0] Sta;
    logic [31:0] Cause;
    logic [31:0] Epc_d;
    logic [31:0] Sta_d;
    logic        Wcau;
    logic        Wepc;
    logic        Wsta;
    logic [1:0]  Selpc;
    logic [31:0] Vec;

    typedef struct {
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] sta;
        logic [2:0]  we;     // {Wcau, Wepc, Wsta}
        logic [1:0]  selpc;
        logic        inta;
    } out_t;

    out_t sb[$];
    int   checks = 0;
    int   errors = 0;

    exc_cause_gen #(
        .VECTOR      (32'h00000008),
        .SYNC_STAGES (2)
    ) dut (
        .Clk    (Clk),
        .Clr    (Clr),
        .Intr   (Intr),
        .Inta   (Inta),
        .Ov     (Ov),
        .Sys    (Sys),
        .Unimpl (Unimpl),
        .Eret   (Eret),
        .Bd     (Bd),
        .Stall  (Stall),
        .Pc     (Pc),
        .Sta    (Sta),
        .Cause  (Cause),
        .Epc_d  (Epc_d),
        .Sta_d  (Sta_d),
        .Wcau   (Wcau),
        .Wepc   (Wepc),
        .Wsta   (Wsta),
        .Selpc  (Selpc),
        .Vec    (Vec)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic out_t mk(input logic [31:0] cause, input logic [31:0] epc,
                                input logic [31:0] sta, input logic [2:0] we,
                                input logic [1:0] selpc, input logic inta);
        out_t r;
        r.cause = cause;
        r.epc   = epc;
        r.sta   = sta;
        r.we    = we;
        r.selpc = selpc;
        r.inta  = inta;
        return r;
    endfunction

    function automatic out_t idle(input logic [31:0] cause, input logic [31:0] epc,
                                  input logic [31:0] sta);
        return mk(cause, epc, sta, 3'b000, 2'b00, 1'b0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare every output against it
    task automatic compare(input string tag);
        out_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty-scoreboard expected=record", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".Cause"}, Cause, e.cause);
            chk({tag, ".Epc_d"}, Epc_d, e.epc);
            chk({tag, ".Sta_d"}, Sta_d, e.sta);
            chk({tag, ".We"},    {29'b0, Wcau, Wepc, Wsta}, {29'b0, e.we});
            chk({tag, ".Selpc"}, {30'b0, Selpc}, {30'b0, e.selpc});
            chk({tag, ".Inta"},  {31'b0, Inta}, {31'b0, e.inta});
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic cyc(input out_t e, input string tag);
        sb.push_back(e);
        @(posedge Clk);
        @(negedge Clk);
        compare(tag);
    endtask

    task automatic clear_ins();
        Ov = 1'b0; Sys = 1'b0; Unimpl = 1'b0; Eret = 1'b0; Bd = 1'b0; Stall = 1'b0;
    endtask

    initial begin
        Clr = 1'b1; Intr = 1'b1; Ov = 1'b1; Sys = 1'b0; Unimpl = 1'b0; Eret = 1'b0;
        Bd = 1'b0; Stall = 1'b0; Pc = 32'h0; Sta = 32'h0;

        // Reset held with Intr and Ov asserted
        chk("vec", Vec, 32'h00000008);
        cyc(idle(32'h0, 32'h0, 32'h0), "rst0");
        cyc(idle(32'h0, 32'h0, 32'h0), "rst1");

        // Release with Sta=0: interrupt only becomes pending
        Clr = 1'b0; Ov = 1'b0;
        cyc(idle(32'h0, 32'h0, 32'h0), "rel1");
        cyc(idle(32'h0, 32'h0, 32'h0), "rel2");
        cyc(idle(32'h0, 32'h0, 32'h0), "rel3");
        cyc(idle(32'h100, 32'h0, 32'h0), "rel_pend");
        cyc(idle(32'h100, 32'h0, 32'h0), "rel_pend2");

        // Fresh reset with Intr low
        Clr = 1'b1; Intr = 1'b0;
        cyc(idle(32'h0, 32'h0, 32'h0), "rst2");
        Clr = 1'b0;

        // Overflow
        Sta = 32'h101; Pc = 32'h40; Ov = 1'b1;
        cyc(mk(32'h30, 32'h40, 32'h103, 3'b111, 2'b10, 1'b0), "ov_enter");
        Ov = 1'b0;
        cyc(idle(32'h30, 32'h40, 32'h103), "ov_idle");

        // Priority in a delay slot
        Unimpl = 1'b1; Sys = 1'b1; Ov = 1'b1; Bd = 1'b1; Pc = 32'h100;
        cyc(mk(32'h80000028, 32'hFC, 32'h103, 3'b111, 2'b10, 1'b0), "prio_enter");
        clear_ins();
        cyc(idle(32'h80000028, 32'hFC, 32'h103), "prio_idle");

        // Delay slot at Pc=0 wraps
        Sys = 1'b1; Bd = 1'b1; Pc = 32'h0;
        cyc(mk(32'h80000020, 32'hFFFFFFFC, 32'h103, 3'b111, 2'b10, 1'b0), "wrap_enter");
        clear_ins();
        cyc(idle(32'h80000020, 32'hFFFFFFFC, 32'h103), "wrap_idle");

        // Back-to-back overflow; second one with EXL already set
        Ov = 1'b1; Pc = 32'h44;
        cyc(mk(32'h30, 32'h44, 32'h103, 3'b111, 2'b10, 1'b0), "b2b_enter1");
        Sta = 32'h103; Pc = 32'h48;
        cyc(idle(32'h30, 32'h44, 32'h103), "b2b_gap");
        cyc(mk(32'h30, 32'h48, 32'h103, 3'b111, 2'b10, 1'b0), "b2b_enter2");
        Ov = 1'b0;
        cyc(idle(32'h30, 32'h48, 32'h103), "b2b_idle");

        // Stalled syscall is not taken
        Sys = 1'b1; Stall = 1'b1;
        cyc(idle(32'h30, 32'h48, 32'h103), "stall_sys");
        clear_ins();

        // Interrupt: entry three cycles after the sampling edge
        Sta = 32'h101; Pc = 32'h200; Intr = 1'b1;
        cyc(idle(32'h30, 32'h48, 32'h103), "int_s1");
        cyc(idle(32'h30, 32'h48, 32'h103), "int_s2");
        cyc(idle(32'h30, 32'h48, 32'h103), "int_s3");
        cyc(mk(32'h100, 32'h200, 32'h103, 3'b111, 2'b10, 1'b1), "int_enter");
        cyc(idle(32'h100, 32'h200, 32'h103), "int_ack");
        cyc(idle(32'h0, 32'h200, 32'h103), "int_clr");
        cyc(idle(32'h0, 32'h200, 32'h103), "int_held");

        // Masked by EXL, then ERET and delayed entry
        Intr = 1'b0;
        cyc(idle(32'h0, 32'h200, 32'h103), "msk_low1");
        cyc(idle(32'h0, 32'h200, 32'h103), "msk_low2");
        cyc(idle(32'h0, 32'h200, 32'h103), "msk_low3");
        Intr = 1'b1; Sta = 32'h103;
        cyc(idle(32'h0, 32'h200, 32'h103), "msk_s1");
        cyc(idle(32'h0, 32'h200, 32'h103), "msk_s2");
        cyc(idle(32'h0, 32'h200, 32'h103), "msk_s3");
        cyc(idle(32'h100, 32'h200, 32'h103), "msk_pend");
        cyc(idle(32'h100, 32'h200, 32'h103), "msk_hold");
        Eret = 1'b1;
        cyc(mk(32'h100, 32'h200, 32'h101, 3'b001, 2'b01, 1'b0), "msk_ret");
        Eret = 1'b0; Sta = 32'h101; Pc = 32'h300;
        cyc(idle(32'h100, 32'h200, 32'h101), "msk_ret_idle");
        cyc(mk(32'h100, 32'h300, 32'h103, 3'b111, 2'b10, 1'b1), "msk_enter");
        cyc(idle(32'h100, 32'h300, 32'h103), "msk_ack");
        cyc(idle(32'h0, 32'h300, 32'h103), "msk_clr");

        // Stall keeps pending; ERET beats a simultaneous interrupt
        Intr = 1'b0;
        cyc(idle(32'h0, 32'h300, 32'h103), "col_low1");
        cyc(idle(32'h0, 32'h300, 32'h103), "col_low2");
        cyc(idle(32'h0, 32'h300, 32'h103), "col_low3");
        Intr = 1'b1; Stall = 1'b1; Sys = 1'b1;
        cyc(idle(32'h0, 32'h300, 32'h103), "col_s1");
        cyc(idle(32'h0, 32'h300, 32'h103), "col_s2");
        cyc(idle(32'h0, 32'h300, 32'h103), "col_s3");
        cyc(idle(32'h100, 32'h300, 32'h103), "col_stall_pend");
        cyc(idle(32'h100, 32'h300, 32'h103), "col_stall_hold");
        Stall = 1'b0; Sys = 1'b0; Eret = 1'b1;
        cyc(mk(32'h100, 32'h300, 32'h101, 3'b001, 2'b01, 1'b0), "col_ret");
        Eret = 1'b0; Pc = 32'h400;
        cyc(idle(32'h100, 32'h300, 32'h101), "col_ret_idle");
        cyc(mk(32'h100, 32'h400, 32'h103, 3'b111, 2'b10, 1'b1), "col_enter");
        cyc(idle(32'h100, 32'h400, 32'h103), "col_ack");

        // Reset in the middle of an entry
        Intr = 1'b0; Ov = 1'b1; Pc = 32'h500;
        cyc(mk(32'h30, 32'h500, 32'h103, 3'b111, 2'b10, 1'b0), "abort_enter");
        Clr = 1'b1;
        #1;
        sb.push_back(idle(32'h0, 32'h0, 32'h0));
        compare("abort_async");
        Ov = 1'b0;
        cyc(idle(32'h0, 32'h0, 32'h0), "abort_hold");
        Clr = 1'b0;
        cyc(idle(32'h0, 32'h0, 32'h0), "abort_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
